// File: rtl/audio_dac_serializer.sv
// Audio DAC serializer: a stereo sample FIFO feeding an I2S master transmitter
// for a WM8731 DAC. This block generates BCLK and DACLRCK itself from clk, and
// every output is registered.
module audio_dac_serializer #(
    parameter int BCLK_HALF  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_audio_out_memory,
    input  logic [15:0] left_channel_audio_out,
    input  logic [15:0] right_channel_audio_out,
    input  logic        write_audio_out,
    output logic        audio_out_allowed,
    output logic [2:0]  fifo_level,
    output logic        underrun,
    output logic        AUD_BCLK,
    output logic        AUD_DACLRCK,
    output logic        AUD_DACDAT
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(BCLK_HALF + 1);
    localparam logic [DW-1:0] DIV_TC  = DW'(BCLK_HALF - 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Serial side
    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic          lrck_q, lrck_d;
    logic          dat_q, dat_d;
    logic [15:0]   lsr_q, lsr_d;
    logic [15:0]   rsr_q, rsr_d;
    logic          underrun_q, underrun_d;

    // FIFO side
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          allowed_q, allowed_d;

    logic          bclk_tc;
    logic          bclk_fall;
    logic          frame_start;
    logic          pop_en;
    logic          wr_en;
    logic [31:0]   head;

    assign bclk_tc     = (div_q == DIV_TC);
    assign bclk_fall   = bclk_tc && bclk_q;
    // bit_cnt is about to wrap from 63 to 0: this is where the next frame is loaded.
    assign frame_start = bclk_fall && (bit_cnt_q == 6'd63);
    assign pop_en      = frame_start && (count_q != '0);
    // A write into an empty FIFO on the pop cycle is only stored, not popped.
    // The frame therefore underruns.
    assign wr_en       = write_audio_out && allowed_q && !clear_audio_out_memory;
    assign head        = mem_q[rd_ptr_q];

    // Bit-clock divider and serial shifter next state; DACLRCK/DACDAT move only on BCLK falls
    always_comb begin
        div_d      = bclk_tc ? '0 : div_q + DW'(1);
        bclk_d     = bclk_tc ? ~bclk_q : bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrck_d     = lrck_q;
        dat_d      = dat_q;
        lsr_d      = lsr_q;
        rsr_d      = rsr_q;
        underrun_d = frame_start && (count_q == '0);
        if (bclk_fall) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrck_d    = bit_cnt_d[5];
            dat_d     = 1'b0;
            if (bit_cnt_d == 6'd0) begin
                lsr_d = pop_en ? head[31:16] : 16'h0000;
                rsr_d = pop_en ? head[15:0]  : 16'h0000;
            end else if (bit_cnt_d <= 6'd16) begin
                dat_d = lsr_q[15];
                lsr_d = {lsr_q[14:0], 1'b0};
            end else if (bit_cnt_d >= 6'd33 && bit_cnt_d <= 6'd48) begin
                dat_d = rsr_q[15];
                rsr_d = {rsr_q[14:0], 1'b0};
            end
        end
    end

    // FIFO pointer, level and write-permission next state; clear overrides a write
    always_comb begin
        wr_ptr_d = wr_en  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({wr_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clear_audio_out_memory) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        allowed_d = (count_d < DEPTH_C);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            bit_cnt_q  <= 6'd63;
            lrck_q     <= 1'b1;
            dat_q      <= 1'b0;
            lsr_q      <= '0;
            rsr_q      <= '0;
            underrun_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            allowed_q  <= 1'b1;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            bit_cnt_q  <= bit_cnt_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            lsr_q      <= lsr_d;
            rsr_q      <= rsr_d;
            underrun_q <= underrun_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            allowed_q  <= allowed_d;
        end
    end

    // Sample storage; contents are don't-care until written, so it needs no reset
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem_q[wr_ptr_q] <= {left_channel_audio_out, right_channel_audio_out};
        end
    end

    assign audio_out_allowed = allowed_q;
    assign fifo_level        = 3'(count_q);
    assign underrun          = underrun_q;
    assign AUD_BCLK          = bclk_q;
    assign AUD_DACLRCK       = lrck_q;
    assign AUD_DACDAT        = dat_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer. The driver keeps a queue model of the FIFO
// and works out the frame timing from the clock count since reset. It checks
// the level, permission, underrun and clock outputs every cycle. Each popped
// frame goes onto a scoreboard queue. The monitor acts as an I2S receiver:
// it rebuilds each 64-bit frame from the serial pins and compares it against
// that queue.
module tb_audio_dac_serializer;

    localparam int BH = 8;
    localparam int FD = 4;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        bit          ur;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear_audio_out_memory = 1'b0;
    logic [15:0] left_channel_audio_out = '0;
    logic [15:0] right_channel_audio_out = '0;
    logic        write_audio_out = 1'b0;
    logic        audio_out_allowed;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;

    audio_dac_serializer #(.BCLK_HALF(BH), .FIFO_DEPTH(FD)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .clear_audio_out_memory  (clear_audio_out_memory),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .write_audio_out         (write_audio_out),
        .audio_out_allowed       (audio_out_allowed),
        .fifo_level              (fifo_level),
        .underrun                (underrun),
        .AUD_BCLK                (AUD_BCLK),
        .AUD_DACLRCK             (AUD_DACLRCK),
        .AUD_DACDAT              (AUD_DACDAT)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          n = 0;
    logic [31:0] mq[$];
    frame_t      expq[$];
    bit          m_allowed = 1'b1;
    bit          m_ur = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (n=%0d, t=%0t)", nm, act, exp, n, $time);
        end
    endtask

    // One clk cycle: drive inputs, advance the model at the edge, then check outputs
    task automatic cyc(input bit rst, input bit wr, input bit clr,
                       input logic [15:0] l, input logic [15:0] r);
        int bitn;
        frame_t f;
        reset_n                 = !rst;
        write_audio_out         = wr;
        clear_audio_out_memory  = clr;
        left_channel_audio_out  = l;
        right_channel_audio_out = r;
        @(posedge clk);
        m_ur = 1'b0;
        if (rst) begin
            n = 0;
            mq.delete();
            expq.delete();
            m_allowed = 1'b1;
        end else begin
            n++;
            if (n >= 16 && (n - 16) % 1024 == 0) begin
                if (mq.size() > 0) begin
                    f.l  = mq[0][31:16];
                    f.r  = mq[0][15:0];
                    f.ur = 1'b0;
                    void'(mq.pop_front());
                end else begin
                    f.l  = '0;
                    f.r  = '0;
                    f.ur = 1'b1;
                    m_ur = 1'b1;
                end
                expq.push_back(f);
            end
            if (wr && m_allowed && !clr) mq.push_back({l, r});
            if (clr) mq.delete();
            m_allowed = (mq.size() < FD);
        end
        #2;
        bitn = (63 + n / (2 * BH)) % 64;
        chk("fifo_level", 64'(fifo_level), 64'(mq.size()));
        chk("audio_out_allowed", 64'(audio_out_allowed), 64'(m_allowed));
        chk("underrun", 64'(underrun), 64'(m_ur));
        chk("AUD_BCLK", 64'(AUD_BCLK), 64'((n / BH) % 2));
        chk("AUD_DACLRCK", 64'(AUD_DACLRCK), 64'(bitn >= 32));
        if (rst) chk("AUD_DACDAT_reset", 64'(AUD_DACDAT), 64'd0);
    endtask

    task automatic idle_to(input int target);
        while (n < target) cyc(0, 0, 0, 16'h0, 16'h0);
    endtask

    // I2S receiver: samples pins on BCLK rises and scores each complete frame
    initial begin
        bit          prev_bclk = 1'b0;
        bit          prev_lrck = 1'b1;
        bit          in_frame = 1'b0;
        bit          ur_since = 1'b0;
        bit          fr_ur = 1'b0;
        int          idx = 0;
        logic [63:0] lr_v;
        logic [63:0] dat_v;
        logic [63:0] e_lr;
        logic [63:0] e_dat;
        frame_t      e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_bclk = 1'b0;
                prev_lrck = 1'b1;
                in_frame  = 1'b0;
                ur_since  = 1'b0;
            end else begin
                if (underrun) ur_since = 1'b1;
                if (AUD_BCLK && !prev_bclk) begin
                    if (!AUD_DACLRCK && prev_lrck) begin
                        in_frame = 1'b1;
                        idx      = 0;
                        fr_ur    = ur_since;
                        ur_since = 1'b0;
                        lr_v     = '0;
                        dat_v    = '0;
                    end
                    if (in_frame) begin
                        lr_v[idx]  = AUD_DACLRCK;
                        dat_v[idx] = AUD_DACDAT;
                        idx++;
                        if (idx == 64) begin
                            in_frame = 1'b0;
                            if (expq.size() == 0) begin
                                chk("frame_expected", 64'd1, 64'd0);
                            end else begin
                                e = expq.pop_front();
                                for (int i = 0; i < 64; i++) begin
                                    e_lr[i]  = (i >= 32);
                                    if (i >= 1 && i <= 16)       e_dat[i] = e.l[16 - i];
                                    else if (i >= 33 && i <= 48) e_dat[i] = e.r[48 - i];
                                    else                         e_dat[i] = 1'b0;
                                end
                                chk("frame_lrck", lr_v, e_lr);
                                chk("frame_data", dat_v, e_dat);
                                chk("frame_underrun", 64'(fr_ur), 64'(e.ur));
                            end
                        end
                    end
                    prev_lrck = AUD_DACLRCK;
                end
                prev_bclk = AUD_BCLK;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at n=%0d", n);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc(1, 0, 0, 16'h0, 16'h0);

        // Known pattern frame, then five back-to-back writes into an empty FIFO
        cyc(0, 1, 0, 16'hA5C3, 16'h0F0F);
        idle_to(20);
        repeat (5) cyc(0, 1, 0, 16'($urandom), 16'($urandom));
        idle_to(1034);

        // Write held high across a pop while full
        while (n < 1046) cyc(0, 1, 0, 16'($urandom), 16'($urandom));
        idle_to(4200);

        // Sparse random writes with occasional clears kept off pop cycles
        repeat (6000) begin
            bit wr;
            bit clr;
            wr  = ($urandom_range(0, 1023) < 3);
            clr = ($urandom_range(0, 1499) == 0) && (((n + 1 - 16) % 1024) != 0);
            cyc(0, wr, clr, 16'($urandom), 16'($urandom));
        end

        // Level 3, then clear together with a write; the next frame must underrun
        cyc(1, 0, 0, 16'h0, 16'h0);
        repeat (3) cyc(0, 1, 0, 16'($urandom), 16'($urandom));
        cyc(0, 1, 1, 16'h1234, 16'h5678);
        idle_to(1100);

        // Reset for one clk at bit_cnt 40 of a data-carrying frame, then idle run
        cyc(1, 0, 0, 16'h0, 16'h0);
        cyc(0, 1, 0, 16'hFFFF, 16'h8001);
        idle_to(656 + 2 * BH / 2);
        cyc(1, 0, 0, 16'h0, 16'h0);
        idle_to(2200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
